// File: rtl/pong_pkg.sv
// Shared constants for the pong game: FSM state codes and
// playfield geometry used alongside the ball re-centre strobe.
package pong_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SERVE     = 3'd1;
  localparam logic [2:0] ST_PLAY      = 3'd2;
  localparam logic [2:0] ST_POINT     = 3'd3;
  localparam logic [2:0] ST_GAME_OVER = 3'd4;

  localparam int unsigned PADDLE_ONE_X = 20;
  localparam int unsigned PADDLE_TWO_X = 610;
  localparam int unsigned BALL_SIZE    = 10;
  localparam int unsigned CENTER_X     = 315;
  localparam int unsigned CENTER_Y     = 235;

  typedef logic [1:0] speed_t;

endpackage

// File: rtl/pong_match_controller_if.sv
// Bundle between the match controller and the ball movement datapath.
interface pong_match_controller_if;
  import pong_pkg::*;

  logic   collided;
  logic   miss_left;
  logic   miss_right;
  logic   ball_run;
  logic   ball_center;
  logic   serve_dir;
  speed_t speed_level;

  modport master (
    input  collided, miss_left, miss_right,
    output ball_run, ball_center, serve_dir, speed_level
  );

  modport slave (
    output collided, miss_left, miss_right,
    input  ball_run, ball_center, serve_dir, speed_level
  );

endinterface

// File: rtl/frame_tick_gen.sv
// Rising-edge detector turning the end-of-frame level into a
// single-clock frame tick.
module frame_tick_gen (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic tick_o
);

  logic eof_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) eof_q <= 1'b0;
    else         eof_q <= level_i;
  end

  assign tick_o = level_i & ~eof_q;

endmodule

// File: rtl/pong_match_controller.sv
// Match sequencer: serve countdown, play, point pause, game over,
// scores and rally speed level. All timing is in video frames.
module pong_match_controller
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES   = 60,
  parameter int POINT_FRAMES   = 30,
  parameter int WIN_SCORE      = 7,
  parameter int HITS_PER_LEVEL = 4
) (
  input  logic                           clk50M,
  input  logic                           reset_n,
  input  logic                           endofframe,
  input  logic                           start,
  pong_match_controller_if.master        ball,
  output logic [3:0]                     score_one,
  output logic [3:0]                     score_two,
  output logic                           game_over,
  output logic                           winner,
  output logic [2:0]                     state
);

  logic       tick;
  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] s1_q, s1_d, s2_q, s2_d;
  logic [3:0] hits_q, hits_d;
  speed_t     spd_q, spd_d;
  logic       dir_q, dir_d;
  logic       win_q, win_d;
  logic       colp_q, start_q;
  logic       ent_q, ctr_q, run_q, dir_o_q;
  speed_t     spd_o_q;
  logic       hit_edge, start_rise, serve_entry, win_reached;

  frame_tick_gen u_tick (
    .clk_i   (clk50M),
    .rst_ni  (reset_n),
    .level_i (endofframe),
    .tick_o  (tick)
  );

  assign hit_edge    = ball.collided & ~colp_q;
  assign start_rise  = start & ~start_q;
  assign win_reached = (s1_q == 4'(WIN_SCORE)) |
                       (s2_q == 4'(WIN_SCORE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    hits_d  = hits_q;
    spd_d   = spd_q;
    dir_d   = dir_q;
    win_d   = win_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SERVE;
      end
      ST_SERVE: begin
        if (tick) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // misses outrank hits; left miss outranks right miss
        if (tick) begin
          if (ball.miss_left) begin
            s2_d    = s2_q + 4'd1;
            dir_d   = 1'b1;
            win_d   = 1'b1;
            cnt_d   = 8'(POINT_FRAMES);
            state_d = ST_POINT;
          end else if (ball.miss_right) begin
            s1_d    = s1_q + 4'd1;
            dir_d   = 1'b0;
            win_d   = 1'b0;
            cnt_d   = 8'(POINT_FRAMES);
            state_d = ST_POINT;
          end else if (hit_edge) begin
            if (hits_q == 4'(HITS_PER_LEVEL - 1)) begin
              hits_d = 4'd0;
              if (spd_q != 2'd3) spd_d = spd_q + 2'd1;
            end else begin
              hits_d = hits_q + 4'd1;
            end
          end
        end
      end
      ST_POINT: begin
        if (tick) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1)
            state_d = win_reached ? ST_GAME_OVER : ST_SERVE;
        end
      end
      ST_GAME_OVER: begin
        if (start_rise) begin
          s1_d    = 4'd0;
          s2_d    = 4'd0;
          state_d = ST_SERVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    serve_entry = (state_d == ST_SERVE) && (state_q != ST_SERVE);
    if (serve_entry) begin
      cnt_d  = 8'(SERVE_FRAMES);
      spd_d  = 2'd0;
      hits_d = 4'd0;
    end
  end

  always_ff @(posedge clk50M) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      s1_q    <= 4'd0;
      s2_q    <= 4'd0;
      hits_q  <= 4'd0;
      spd_q   <= 2'd0;
      dir_q   <= 1'b0;
      win_q   <= 1'b0;
      colp_q  <= 1'b0;
      start_q <= 1'b0;
      ent_q   <= 1'b0;
      ctr_q   <= 1'b0;
      run_q   <= 1'b0;
      dir_o_q <= 1'b0;
      spd_o_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      hits_q  <= hits_d;
      spd_q   <= spd_d;
      dir_q   <= dir_d;
      win_q   <= win_d;
      if (tick) colp_q <= ball.collided;
      start_q <= start;
      ent_q   <= serve_entry;
      ctr_q   <= ent_q;
      run_q   <= (state_q == ST_PLAY);
      dir_o_q <= dir_q;
      spd_o_q <= spd_q;
    end
  end

  assign ball.ball_run    = run_q;
  assign ball.ball_center = ctr_q;
  assign ball.serve_dir   = dir_o_q;
  assign ball.speed_level = spd_o_q;
  assign score_one        = s1_q;
  assign score_two        = s2_q;
  assign game_over        = (state_q == ST_GAME_OVER);
  assign winner           = win_q;
  assign state            = state_q;

endmodule

// File: tb/tb_pong_match_controller.sv
// Bench for pong_match_controller: directed scenarios plus random
// rallies checked against a frame-level model of the match rules.
module tb_pong_match_controller;

  localparam int SF  = 60;
  localparam int PF  = 30;
  localparam int WIN = 4;
  localparam int HPL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       eof = 1'b0;
  logic       start = 1'b0;
  logic [3:0] s1, s2;
  logic       go, win;
  logic [2:0] st;

  int passed = 0;
  int total  = 0;

  int m_st, m_left, m_s1, m_s2, m_hits, m_spd, m_dir, m_win;
  int m_prevcol, m_center, obs_bc;

  always #5 clk = ~clk;

  pong_match_controller_if bif ();

  pong_match_controller #(
    .SERVE_FRAMES   (SF),
    .POINT_FRAMES   (PF),
    .WIN_SCORE      (WIN),
    .HITS_PER_LEVEL (HPL)
  ) dut (
    .clk50M     (clk),
    .reset_n    (rst_n),
    .endofframe (eof),
    .start      (start),
    .ball       (bif),
    .score_one  (s1),
    .score_two  (s2),
    .game_over  (go),
    .winner     (win),
    .state      (st)
  );

  function automatic logic [15:0] exp_vec();
    return {3'(m_st), 4'(m_s1), 4'(m_s2), 2'(m_spd),
            m_st == 2, 1'(m_dir), m_st == 4};
  endfunction

  function automatic logic [15:0] obs_vec();
    return {st, s1, s2, bif.speed_level, bif.ball_run,
            bif.serve_dir, go};
  endfunction

  task automatic model_reset();
    m_st = 0; m_left = 0; m_s1 = 0; m_s2 = 0; m_hits = 0;
    m_spd = 0; m_dir = 0; m_win = 0; m_prevcol = 0; m_center = 0;
  endtask

  task automatic model_serve_entry();
    m_st = 1; m_left = SF; m_spd = 0; m_hits = 0; m_center = 1;
  endtask

  // one video frame: model update, then drive a tick and watch 4 clocks
  task automatic frame(input logic col, input logic ml, input logic mr);
    bit hit;
    m_center = 0;
    hit = col && (m_prevcol == 0);
    m_prevcol = col;
    case (m_st)
      1: begin
        m_left--;
        if (m_left == 0) m_st = 2;
      end
      2: begin
        if (ml) begin
          m_s2++; m_dir = 1; m_win = 1; m_st = 3; m_left = PF;
        end else if (mr) begin
          m_s1++; m_dir = 0; m_win = 0; m_st = 3; m_left = PF;
        end else if (hit) begin
          m_hits++;
          if (m_hits == HPL) begin
            m_hits = 0;
            if (m_spd < 3) m_spd++;
          end
        end
      end
      3: begin
        m_left--;
        if (m_left == 0) begin
          if (m_s1 == WIN || m_s2 == WIN) m_st = 4;
          else model_serve_entry();
        end
      end
      default: ;
    endcase
    @(negedge clk);
    bif.collided = col; bif.miss_left = ml; bif.miss_right = mr;
    eof = 1'b1;
    obs_bc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bif.ball_center) obs_bc++;
      if (k == 1) eof = 1'b0;
    end
  endtask

  task automatic press_start();
    m_center = 0;
    if (m_st == 0) model_serve_entry();
    else if (m_st == 4) begin
      m_s1 = 0; m_s2 = 0; model_serve_entry();
    end
    @(negedge clk);
    start = 1'b1;
    obs_bc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bif.ball_center) obs_bc++;
      if (k == 0) start = 1'b0;
    end
  endtask

  task automatic run_to_play();
    int n = 0;
    while (m_st != 2 && n < 200) begin
      frame(1'b0, 1'b0, 1'b0);
      n++;
    end
    total++;
    if (st !== 3'd2) $display("FAIL run_to_play: state %0d want 2", st);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    total++;
    if (obs_vec() !== 16'h0) $display("FAIL reset_vec: got %h want 0000", obs_vec());
    else passed++;
    total++;
    if ({bif.ball_center, win} !== 2'b00) $display("FAIL reset_bc_win: got %b want 00", {bif.ball_center, win});
    else passed++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (st !== 3'd0) $display("FAIL reset_idle: state %0d want 0", st);
    else passed++;
  endtask

  task automatic test_serve();
    press_start();
    total++;
    if (obs_bc !== 1) $display("FAIL serve_center: pulses %0d want 1", obs_bc);
    else passed++;
    total++;
    if (st !== 3'd1) $display("FAIL serve_state: state %0d want 1", st);
    else passed++;
    for (int i = 1; i <= SF; i++) begin
      frame(1'b0, 1'b0, 1'b0);
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL serve_frame%0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
    end
    total++;
    if ({st, bif.ball_run} !== {3'd2, 1'b1}) $display("FAIL serve_to_play: got %0d/%b want 2/1", st, bif.ball_run);
    else passed++;
  endtask

  task automatic test_point_right();
    frame(1'b0, 1'b0, 1'b1);
    total++;
    if (obs_vec() !== exp_vec()) $display("FAIL point_right: got %h want %h", obs_vec(), exp_vec());
    else passed++;
    for (int i = 1; i <= PF; i++) begin
      frame(1'b0, 1'b0, 1'b0);
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL point_pause%0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
    end
    total++;
    if ({st, 3'(obs_bc)} !== {3'd1, 3'd1}) $display("FAIL point_reserve: state %0d pulses %0d want 1/1", st, obs_bc);
    else passed++;
    run_to_play();
  endtask

  task automatic test_speed();
    for (int e = 0; e < 16; e++) begin
      frame(1'b1, 1'b0, 1'b0);
      frame(1'b1, 1'b0, 1'b0);
      frame(1'b1, 1'b0, 1'b0);
      frame(1'b0, 1'b0, 1'b0);
      if (e == 3 || e == 7 || e == 15) begin
        total++;
        if (bif.speed_level !== 2'(m_spd)) $display("FAIL speed_e%0d: got %0d want %0d", e + 1, bif.speed_level, m_spd);
        else passed++;
      end
    end
    total++;
    if (bif.speed_level !== 2'd3) $display("FAIL speed_sat: got %0d want 3", bif.speed_level);
    else passed++;
    frame(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < PF; i++) frame(1'b0, 1'b0, 1'b0);
    total++;
    if ({st, bif.speed_level} !== {3'd1, 2'd0}) $display("FAIL speed_clear: got %0d/%0d want 1/0", st, bif.speed_level);
    else passed++;
    run_to_play();
  endtask

  task automatic test_miss_combo();
    frame(1'b1, 1'b1, 1'b0);
    total++;
    if (obs_vec() !== exp_vec()) $display("FAIL miss_and_hit: got %h want %h", obs_vec(), exp_vec());
    else passed++;
    run_to_play();
    frame(1'b0, 1'b1, 1'b1);
    total++;
    if (obs_vec() !== exp_vec()) $display("FAIL miss_both: got %h want %h", obs_vec(), exp_vec());
    else passed++;
    total++;
    if ({s1, s2, bif.serve_dir} !== {4'd2, 4'd2, 1'b1}) $display("FAIL miss_both_score: got %0d/%0d dir %b want 2/2 dir 1", s1, s2, bif.serve_dir);
    else passed++;
    run_to_play();
  endtask

  task automatic test_reset_mid_play();
    frame(1'b0, 1'b0, 1'b1);
    run_to_play();
    repeat (3) frame(1'b0, 1'b0, 1'b0);
    total++;
    if ({s1, s2} !== {4'd3, 4'd2}) $display("FAIL pre_reset_score: got %0d/%0d want 3/2", s1, s2);
    else passed++;
    @(negedge clk);
    rst_n = 1'b0;
    eof = 1'b1;
    model_reset();
    @(negedge clk);
    total++;
    if (obs_vec() !== 16'h0) $display("FAIL mid_reset_vec: got %h want 0000", obs_vec());
    else passed++;
    total++;
    if ({bif.ball_center, win} !== 2'b00) $display("FAIL mid_reset_bc_win: got %b want 00", {bif.ball_center, win});
    else passed++;
    repeat (3) @(negedge clk);
    eof = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (st !== 3'd0) $display("FAIL post_reset_idle: state %0d want 0", st);
    else passed++;
  endtask

  task automatic test_game_over();
    press_start();
    for (int p = 0; p < WIN; p++) begin
      run_to_play();
      frame(1'b0, 1'b1, 1'b0);
    end
    start = 1'b1;
    for (int i = 0; i < PF; i++) frame(1'b0, 1'b0, 1'b0);
    total++;
    if (obs_vec() !== exp_vec()) $display("FAIL game_over_vec: got %h want %h", obs_vec(), exp_vec());
    else passed++;
    total++;
    if ({st, go, win} !== {3'd4, 1'b1, 1'b1}) $display("FAIL game_over: got st %0d go %b win %b want 4/1/1", st, go, win);
    else passed++;
    repeat (10) @(negedge clk);
    total++;
    if (st !== 3'd4) $display("FAIL held_start: state %0d want 4", st);
    else passed++;
    start = 1'b0;
    repeat (3) @(negedge clk);
    press_start();
    total++;
    if ({st, s1, s2, 3'(obs_bc)} !== {3'd1, 4'd0, 4'd0, 3'd1}) $display("FAIL restart: st %0d score %0d/%0d pulses %0d want 1 0/0 1", st, s1, s2, obs_bc);
    else passed++;
  endtask

  task automatic test_random();
    logic col, ml, mr;
    for (int n = 0; n < 900; n++) begin
      if (m_st == 0 || m_st == 4) begin
        press_start();
      end else begin
        col = ($urandom_range(0, 2) == 0);
        ml  = ($urandom_range(0, 24) == 0);
        mr  = ($urandom_range(0, 24) == 0);
        frame(col, ml, mr);
      end
      total++;
      if (obs_vec() !== exp_vec() || obs_bc !== m_center) $display("FAIL random%0d: got %h/%0d want %h/%0d", n, obs_vec(), obs_bc, exp_vec(), m_center);
      else passed++;
      if (m_st == 4) begin
        total++;
        if (win !== 1'(m_win)) $display("FAIL random_winner%0d: got %b want %0d", n, win, m_win);
        else passed++;
      end
    end
  endtask

  initial begin
    bif.collided = 1'b0;
    bif.miss_left = 1'b0;
    bif.miss_right = 1'b0;
    test_reset();
    test_serve();
    test_point_right();
    test_speed();
    test_miss_combo();
    test_reset_mid_play();
    test_game_over();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
